mux8_scan_seq: RTL and testbench
================================

// Module: mux8_scan_seq
//
// PURPOSE
//   Select-line sequencer and collector placed directly upstream of an 8:1 mux.
//   On start it steps s2,s1,s0 through 0..7 and holds each code for SETTLE_CYCLES
//   cycles. It samples the mux output y into bit [select] of an 8-bit word.
//   When all eight channels are captured, it offers the word on a valid/ready
//   handshake to the downstream consumer.
//
// PARAMETERS
//   SETTLE_CYCLES  1  cycles each select code is held before y is sampled; legal 1..2**CNT_W
//   CNT_W          4  width of the internal settle counter
//
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  reset; asynchronous, active-high
//   start       in   1  begin scan; sampled in IDLE only
//   y           in   1  mux output being scanned
//   s0,s1,s2    out  1  mux select lines; {s2,s1,s0} = current channel
//   busy        out  1  high in any state except IDLE
//   data_out    out  8  assembled word; bit i = y sampled while select = i
//   data_valid  out  1  word complete and stable
//   data_ready  in   1  consumer accepts the word when data_valid && data_ready
//
// BEHAVIOUR
//   Reset (async, rst=1): state IDLE, {s2,s1,s0}=0, busy=0, data_out=8'h00,
//   data_valid=0, counter=0. Reset takes effect immediately; a scan in
//   progress is aborted with no partial output.
//   Interface: one clock (clk); reset is asynchronous, active-high (rst).
//   FSM states: IDLE, SETTLE, HOLD.
//   - IDLE: select=0, busy=0. On an edge with start=1: data_out<=0, sel<=0,
//     cnt<=0, go to SETTLE.
//   - SETTLE: select lines drive sel; busy=1.
//     - If cnt != SETTLE_CYCLES-1: cnt++.
//     - Otherwise: data_out[sel]<=y and cnt<=0. If sel==7, go to HOLD;
//       otherwise sel<=sel+1.
//   - HOLD: data_valid=1; select stays 3'b111; data_out is frozen. When
//     data_ready=1 at an edge, the word transfers and the FSM goes to IDLE
//     (data_valid drops after that edge).
//   Latency: if start is sampled at edge k, channel i is sampled at edge
//     k+(i+1)*SETTLE_CYCLES. data_valid rises after edge k+8*SETTLE_CYCLES
//     (8 cycles at the default).
//   Boundaries:
//   - start outside IDLE is ignored, including start coincident with the
//     handshake.
//   - data_ready outside HOLD is ignored.
//   - sel does not wrap; the scan ends at channel 7.
//   - data_out bits are valid only while data_valid=1.
//   - SETTLE_CYCLES=0 is illegal; the implementation issues a simulation
//     $error at time 0.
//
// CONFIGURATION
//   MUX8_SCAN_CONTINUOUS_EN defined:
//   - HOLD with data_ready=1 goes directly to SETTLE with sel=0, cnt=0,
//     data_out<=0.
//   - Scans therefore run back-to-back with no IDLE cycle. start is needed
//     only for the first scan.
//   - A reset returns the block to IDLE.
//   Undefined: behaviour is exactly as above (single scan per start).
//
// TESTING
//   1 Behavioural 8:1 mux model fed inputs 8'hA5, SETTLE_CYCLES=1, start pulse
//     -> select steps 0..7 one cycle each; data_valid after 8 cycles;
//     data_out=8'hA5.
//   2 SETTLE_CYCLES=3, inputs 8'h5A -> each select held exactly 3 cycles;
//     data_valid after 24 cycles; data_out=8'h5A.
//   3 Backpressure: data_ready low for 5 cycles in HOLD -> data_valid stays 1,
//     data_out and select=7 stable; IDLE one edge after data_ready=1.
//   4 start pulsed at sel=3 and during HOLD -> ignored; exactly one word
//     produced; no restart.
//   5 rst asserted mid-scan at sel=4 -> all outputs 0 without waiting for an
//     edge; FSM in IDLE; a new start produces a correct word.
//   6 With MUX8_SCAN_CONTINUOUS_EN, inputs switch from 8'h3C to 8'hC3 between
//     scans, data_ready=1 -> words 8'h3C then 8'hC3; second scan's select=0
//     the cycle after handshake.

Source files
------------

// File: rtl/mux8_scan_seq.sv
// Steps the select lines of an 8:1 mux through channels 0..7 and assembles
// the sampled y bits into a word offered on a valid/ready handshake.
// Build option MUX8_SCAN_CONTINUOUS_EN: an accepted word immediately starts the next scan.
//
// state  | meaning
// IDLE   | waiting for start; select parked at 0
// SETTLE | holding current select code, sampling y at terminal count
// HOLD   | word complete, data_valid high until data_ready

module mux8_scan_seq #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("mux8_scan_seq: SETTLE_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES > (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("mux8_scan_seq: SETTLE_CYCLES exceeds 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = 8'h00;
                    sel_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != CNT_TC) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    data_d[sel_q] = y;
                    cnt_d         = '0;
                    if (sel_q == 3'd7) begin
                        state_d = HOLD;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (data_ready) begin
                    sel_d = 3'd0;
                    cnt_d = '0;
`ifdef MUX8_SCAN_CONTINUOUS_EN
                    data_d  = 8'h00;
                    state_d = SETTLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
        // Status outputs are registered alongside the state they describe.
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign s2         = sel_q[2];
    assign busy       = busy_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// Scoreboard bench for mux8_scan_seq: two instances (settle 1 and settle 3)
// scan behavioural 8:1 muxes; a monitor checks every accepted word.

module tb_mux8_scan_seq;

    logic       clk;
    logic       rst;

    logic       start1, ready1, s0_1, s1_1, s2_1, busy1, valid1;
    logic [7:0] mux_in1, dout1;
    logic       y1;

    logic       start3, ready3, s0_3, s1_3, s2_3, busy3, valid3;
    logic [7:0] mux_in3, dout3;
    logic       y3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q1[$];
    logic [7:0] q3[$];

    assign y1 = mux_in1[{s2_1, s1_1, s0_1}];
    assign y3 = mux_in3[{s2_3, s1_3, s0_3}];

    mux8_scan_seq #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1),
        .s0(s0_1), .s1(s1_1), .s2(s2_1), .busy(busy1),
        .data_out(dout1), .data_valid(valid1), .data_ready(ready1)
    );

    mux8_scan_seq #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .y(y3),
        .s0(s0_3), .s1(s1_3), .s2(s2_3), .busy(busy3),
        .data_out(dout3), .data_valid(valid3), .data_ready(ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge sees a stable handshake.
    always @(negedge clk) begin
        if (!rst && valid1 && ready1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected word", {24'd0, dout1}, 32'hFFFF_FFFF);
            end else begin
                chk("dut1 word", {24'd0, dout1}, {24'd0, q1.pop_front()});
            end
        end
        if (!rst && valid3 && ready3) begin
            if (q3.size() == 0) begin
                chk("dut3 unexpected word", {24'd0, dout3}, 32'hFFFF_FFFF);
            end else begin
                chk("dut3 word", {24'd0, dout3}, {24'd0, q3.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        start1 = 1'b0; ready1 = 1'b0; mux_in1 = 8'h00;
        start3 = 1'b0; ready3 = 1'b0; mux_in3 = 8'h00;
        cyc(2);
        chk("rst sel", {29'd0, s2_1, s1_1, s0_1}, 32'd0);
        chk("rst busy", {31'd0, busy1}, 32'd0);
        chk("rst valid", {31'd0, valid1}, 32'd0);
        chk("rst data", {24'd0, dout1}, 32'd0);
        rst = 1'b0;
        cyc(1);

`ifndef MUX8_SCAN_CONTINUOUS_EN
        // Single scan of 0xA5 with one-cycle settle.
        mux_in1 = 8'hA5;
        start1  = 1'b1;
        q1.push_back(8'hA5);
        for (int j = 0; j < 8; j++) begin
            cyc(1);
            start1 = 1'b0;
            chk("t1 sel step", {29'd0, s2_1, s1_1, s0_1}, j);
            chk("t1 busy", {31'd0, busy1}, 32'd1);
            chk("t1 valid low", {31'd0, valid1}, 32'd0);
        end
        cyc(1);
        chk("t1 valid", {31'd0, valid1}, 32'd1);
        chk("t1 data", {24'd0, dout1}, 32'hA5);

        // Backpressure: five cycles with ready low in HOLD.
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            chk("t3 valid held", {31'd0, valid1}, 32'd1);
            chk("t3 data held", {24'd0, dout1}, 32'hA5);
            chk("t3 sel held", {29'd0, s2_1, s1_1, s0_1}, 32'd7);
        end
        ready1 = 1'b1;
        cyc(1);
        ready1 = 1'b0;
        chk("t3 valid drop", {31'd0, valid1}, 32'd0);
        chk("t3 idle busy", {31'd0, busy1}, 32'd0);
        chk("t3 idle sel", {29'd0, s2_1, s1_1, s0_1}, 32'd0);

        // Settle of three cycles on the second instance, 0x5A.
        mux_in3 = 8'h5A;
        start3  = 1'b1;
        q3.push_back(8'h5A);
        for (int j = 0; j < 24; j++) begin
            cyc(1);
            start3 = 1'b0;
            chk("t2 sel hold", {29'd0, s2_3, s1_3, s0_3}, j / 3);
            chk("t2 valid low", {31'd0, valid3}, 32'd0);
        end
        cyc(1);
        chk("t2 valid", {31'd0, valid3}, 32'd1);
        ready3 = 1'b1;
        cyc(1);
        ready3 = 1'b0;
        chk("t2 idle", {31'd0, busy3}, 32'd0);

        // start pulses mid-scan and coincident with the handshake are ignored.
        mux_in1 = 8'h96;
        start1  = 1'b1;
        q1.push_back(8'h96);
        cyc(1);
        start1 = 1'b0;
        cyc(3);
        chk("t4 sel3", {29'd0, s2_1, s1_1, s0_1}, 32'd3);
        start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        chk("t4 sel4", {29'd0, s2_1, s1_1, s0_1}, 32'd4);
        cyc(4);
        chk("t4 valid", {31'd0, valid1}, 32'd1);
        start1 = 1'b1;
        ready1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        ready1 = 1'b0;
        chk("t4 no restart", {31'd0, busy1}, 32'd0);
        cyc(12);
        chk("t4 still idle", {31'd0, busy1}, 32'd0);
        chk("t4 no valid", {31'd0, valid1}, 32'd0);

        // Reset mid-scan at channel 4 clears outputs without a clock edge.
        mux_in1 = 8'hFF;
        start1  = 1'b1;
        cyc(1);
        start1 = 1'b0;
        cyc(4);
        chk("t5 sel4", {29'd0, s2_1, s1_1, s0_1}, 32'd4);
        rst = 1'b1;
        #1;
        chk("t5 async sel", {29'd0, s2_1, s1_1, s0_1}, 32'd0);
        chk("t5 async busy", {31'd0, busy1}, 32'd0);
        chk("t5 async data", {24'd0, dout1}, 32'd0);
        chk("t5 async valid", {31'd0, valid1}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        mux_in1 = 8'h69;
        start1  = 1'b1;
        q1.push_back(8'h69);
        cyc(1);
        start1 = 1'b0;
        cyc(8);
        chk("t5 valid", {31'd0, valid1}, 32'd1);
        ready1 = 1'b1;
        cyc(1);
        ready1 = 1'b0;
        chk("t5 done", {31'd0, busy1}, 32'd0);
`else
        // Back-to-back scans: 0x3C then 0xC3 with ready held high.
        ready1  = 1'b1;
        mux_in1 = 8'h3C;
        start1  = 1'b1;
        q1.push_back(8'h3C);
        q1.push_back(8'hC3);
        cyc(1);
        start1 = 1'b0;
        for (int j = 1; j < 8; j++) begin
            cyc(1);
            chk("t6 sel step", {29'd0, s2_1, s1_1, s0_1}, j);
        end
        cyc(1);
        chk("t6 valid1", {31'd0, valid1}, 32'd1);
        chk("t6 data1", {24'd0, dout1}, 32'h3C);
        mux_in1 = 8'hC3;
        cyc(1);
        chk("t6 restart sel", {29'd0, s2_1, s1_1, s0_1}, 32'd0);
        chk("t6 restart busy", {31'd0, busy1}, 32'd1);
        chk("t6 restart valid", {31'd0, valid1}, 32'd0);
        cyc(8);
        chk("t6 valid2", {31'd0, valid1}, 32'd1);
        chk("t6 data2", {24'd0, dout1}, 32'hC3);
        cyc(1);
        ready1 = 1'b0;
        cyc(2);
        rst = 1'b1;
        #1;
        chk("t6 rst idle", {31'd0, busy1}, 32'd0);
        cyc(1);
        rst = 1'b0;
`endif
        cyc(2);
        chk("queue1 drained", q1.size(), 32'd0);
        chk("queue3 drained", q3.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
